// File: rtl/cpu_run_ctrl_if.sv
// Run-controller bus: launch/abort requests and the CPU retire stream in,
// CPU reset/stall controls and run status/counters out.
interface cpu_run_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              start;
  logic              abort;
  logic              retire_valid;
  logic [ADDR_W-1:0] retire_pc;
  logic              cpu_rst;
  logic              cpu_stall;
  logic              running;
  logic              done;
  logic              timeout;
  logic [1:0]        cause;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  retire_count;

  // Harness / CPU side: issues requests and reports retirements.
  modport master (
    output start, abort, retire_valid, retire_pc,
    input  cpu_rst, cpu_stall, running, done, timeout, cause,
           cycle_count, retire_count
  );

  // Controller side.
  modport slave (
    input  start, abort, retire_valid, retire_pc,
    output cpu_rst, cpu_stall, running, done, timeout, cause,
           cycle_count, retire_count
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// CPU run sequencer: issues a programmable-length CPU reset pulse, runs the
// program while counting cycles and retirements, and stops on the end
// address, a cycle limit or a no-retire watchdog. All outputs are registers.
module cpu_run_ctrl #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] END_ADDR    = 'ha0,
  parameter int                RST_CYCLES  = 2,
  parameter int                MAX_CYCLES  = 4096,
  parameter int                WDOG_CYCLES = 64,
  parameter int                CNT_W       = 32
) (
  input logic          clk,
  input logic          rst,
  cpu_run_ctrl_if.slave bus
);

  localparam int RST_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int WDOG_W = $clog2(WDOG_CYCLES);

  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_END   = 2'd1;
  localparam logic [1:0] CAUSE_LIMIT = 2'd2;
  localparam logic [1:0] CAUSE_WDOG  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE,
    S_TIMEOUT
  } state_t;

  state_t            state;
  logic [RST_W-1:0]  rst_cnt;
  logic [WDOG_W-1:0] wdog_cnt;

  // Exit conditions evaluated from registered counters and the retire port.
  logic end_hit;
  logic cyc_limit;
  logic wdog_hit;
  logic cyc_sat;
  logic ret_sat;

  assign end_hit   = bus.retire_valid && (bus.retire_pc == END_ADDR);
  assign cyc_limit = (bus.cycle_count == CYC_LAST);
  assign wdog_hit  = (wdog_cnt == WDOG_LAST) && !bus.retire_valid;
  assign cyc_sat   = &bus.cycle_count;
  assign ret_sat   = &bus.retire_count;

  // Sequencer FSM with registered outputs, counters and watchdog.
  // NOTE: every state register here uses non-blocking assignment so all
  // flops update together from pre-edge values; blocking would chain them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      rst_cnt          <= '0;
      wdog_cnt         <= '0;
      bus.cpu_rst      <= 1'b1;
      bus.cpu_stall    <= 1'b0;
      bus.running      <= 1'b0;
      bus.done         <= 1'b0;
      bus.timeout      <= 1'b0;
      bus.cause        <= CAUSE_NONE;
      bus.cycle_count  <= '0;
      bus.retire_count <= '0;
    end else if (bus.abort) begin
      // Abort outranks everything, including a simultaneous start; counters
      // are kept for post-mortem inspection.
      state         <= S_IDLE;
      bus.cpu_rst   <= 1'b1;
      bus.cpu_stall <= 1'b0;
      bus.running   <= 1'b0;
      bus.done      <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.cause     <= CAUSE_NONE;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (bus.start) begin
            state            <= S_RESET;
            rst_cnt          <= '0;
            wdog_cnt         <= '0;
            bus.cpu_rst      <= 1'b1;
            bus.cpu_stall    <= 1'b0;
            bus.done         <= 1'b0;
            bus.timeout      <= 1'b0;
            bus.cause        <= CAUSE_NONE;
            bus.cycle_count  <= '0;
            bus.retire_count <= '0;
          end
        end

        S_RESET: begin
          if (rst_cnt == RST_LAST) begin
            state       <= S_RUN;
            bus.cpu_rst <= 1'b0;
            bus.running <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end

        S_RUN: begin
          // The limit cycle itself is not counted so the final value reads
          // MAX_CYCLES-1; both counters stick at all-ones rather than wrap.
          if (!cyc_limit && !cyc_sat) bus.cycle_count <= bus.cycle_count + 1'b1;
          if (bus.retire_valid && !ret_sat) bus.retire_count <= bus.retire_count + 1'b1;

          if (bus.retire_valid)  wdog_cnt <= '0;
          else if (!wdog_hit)    wdog_cnt <= wdog_cnt + 1'b1;

          if (end_hit) begin
            state         <= S_DONE;
            bus.cause     <= CAUSE_END;
            bus.running   <= 1'b0;
            bus.done      <= 1'b1;
            bus.cpu_stall <= 1'b1;
          end else if (cyc_limit) begin
            state         <= S_TIMEOUT;
            bus.cause     <= CAUSE_LIMIT;
            bus.running   <= 1'b0;
            bus.timeout   <= 1'b1;
            bus.cpu_stall <= 1'b1;
          end else if (wdog_hit) begin
            state         <= S_TIMEOUT;
            bus.cause     <= CAUSE_WDOG;
            bus.running   <= 1'b0;
            bus.timeout   <= 1'b1;
            bus.cpu_stall <= 1'b1;
          end
        end

        default: begin
          state         <= S_IDLE;
          bus.cpu_rst   <= 1'b1;
          bus.cpu_stall <= 1'b0;
          bus.running   <= 1'b0;
          bus.done      <= 1'b0;
          bus.timeout   <= 1'b0;
          bus.cause     <= CAUSE_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl. Two instances share stimulus: dut_a uses
// default parameters, dut_b uses MAX_CYCLES=16 for cycle-limit and priority
// cases. Inputs change and outputs are sampled on the falling clock edge.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        retire_valid;
  logic [31:0] retire_pc;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_run_ctrl_if #(.ADDR_W(32), .CNT_W(32)) a_if ();
  cpu_run_ctrl_if #(.ADDR_W(32), .CNT_W(32)) b_if ();

  assign a_if.start        = start;
  assign a_if.abort        = abort;
  assign a_if.retire_valid = retire_valid;
  assign a_if.retire_pc    = retire_pc;
  assign b_if.start        = start;
  assign b_if.abort        = abort;
  assign b_if.retire_valid = retire_valid;
  assign b_if.retire_pc    = retire_pc;

  cpu_run_ctrl dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  cpu_run_ctrl #(.MAX_CYCLES(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then return on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start pulse plus the two RESET cycles; returns in RUN cycle 0.
  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    retire_valid = 1'b0;
    retire_pc    = '0;
    #3 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst_cpu_rst",   a_if.cpu_rst, 1);
    check("rst_running",   a_if.running, 0);
    check("rst_done",      a_if.done, 0);
    check("rst_timeout",   a_if.timeout, 0);
    check("rst_stall",     a_if.cpu_stall, 0);
    check("rst_cause",     a_if.cause, 0);
    check("rst_cycles",    a_if.cycle_count, 0);
    check("rst_retires",   a_if.retire_count, 0);

    // Release reset, start sampled at edge 5
    rst = 1'b1;
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("e5_cpu_rst",  a_if.cpu_rst, 1);
    check("e5_running",  a_if.running, 0);
    step();
    check("e6_cpu_rst",  a_if.cpu_rst, 1);
    step();
    check("e7_cpu_rst",  a_if.cpu_rst, 0);
    check("e7_running",  a_if.running, 1);
    check("e7_cycles",   a_if.cycle_count, 0);

    // Retire 0x00..0xa0 every cycle: A completes, B hits its 16-cycle limit
    for (int i = 0; i <= 40; i++) begin
      retire_valid = 1'b1;
      retire_pc    = 32'(i * 4);
      step();
    end
    check("end_done",     a_if.done, 1);
    check("end_timeout",  a_if.timeout, 0);
    check("end_running",  a_if.running, 0);
    check("end_cause",    a_if.cause, 1);
    check("end_retires",  a_if.retire_count, 41);
    check("end_stall",    a_if.cpu_stall, 1);
    check("end_cpu_rst",  a_if.cpu_rst, 0);
    check("lim_timeout",  b_if.timeout, 1);
    check("lim_done",     b_if.done, 0);
    check("lim_cause",    b_if.cause, 2);
    check("lim_cycles",   b_if.cycle_count, 15);
    check("lim_retires",  b_if.retire_count, 16);
    check("lim_stall",    b_if.cpu_stall, 1);

    // Retirements after completion are ignored and state persists
    retire_pc = '0;
    step();
    retire_valid = 1'b0;
    check("hold_retires", a_if.retire_count, 41);
    check("hold_done",    a_if.done, 1);
    check("hold_cause",   a_if.cause, 1);
    check("hold_lim",     b_if.cycle_count, 15);

    // Restart from DONE/TIMEOUT: counters cleared, new reset pulse
    start = 1'b1;
    step();
    start = 1'b0;
    check("rs_cycles",   b_if.cycle_count, 0);
    check("rs_retires",  b_if.retire_count, 0);
    check("rs_cause",    b_if.cause, 0);
    check("rs_cpu_rst",  b_if.cpu_rst, 1);
    check("rs_timeout",  b_if.timeout, 0);
    check("rs_stall",    b_if.cpu_stall, 0);
    check("rs_a_done",   a_if.done, 0);
    step();
    check("rs_pulse",    b_if.cpu_rst, 1);
    step();
    check("rs_run",      b_if.running, 1);
    check("rs_rst_low",  b_if.cpu_rst, 0);

    // Watchdog: one retirement then silence
    retire_valid = 1'b1;
    retire_pc    = 32'h10;
    step();
    retire_valid = 1'b0;
    repeat (63) step();
    check("wd_63_run",   a_if.running, 1);
    check("wd_63_tmo",   a_if.timeout, 0);
    step();
    check("wd_64_tmo",   a_if.timeout, 1);
    check("wd_cause",    a_if.cause, 3);
    check("wd_retires",  a_if.retire_count, 1);
    check("wd_done",     a_if.done, 0);

    // Priority: END_ADDR retires on the cycle-limit cycle of dut_b
    launch();
    for (int i = 0; i < 15; i++) begin
      retire_valid = 1'b1;
      retire_pc    = 32'(i * 4);
      step();
    end
    retire_pc = 32'ha0;
    step();
    retire_valid = 1'b0;
    check("pri_done",    b_if.done, 1);
    check("pri_timeout", b_if.timeout, 0);
    check("pri_cause",   b_if.cause, 1);
    check("pri_retires", b_if.retire_count, 16);

    // Mid-run: start ignored in RUN, then abort together with start
    launch();
    retire_valid = 1'b1;
    retire_pc    = 32'h200;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    retire_valid = 1'b0;
    check("mid_running", a_if.running, 1);
    check("mid_retires", a_if.retire_count, 3);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("ab_cpu_rst",  a_if.cpu_rst, 1);
    check("ab_running",  a_if.running, 0);
    check("ab_cause",    a_if.cause, 0);
    check("ab_stall",    a_if.cpu_stall, 0);
    check("ab_retires",  a_if.retire_count, 3);
    step();
    step();
    check("ab_idle",     a_if.running, 0);
    check("ab_idle_rst", a_if.cpu_rst, 1);

    // Asynchronous reset between edges takes effect immediately
    #2 rst = 1'b0;
    #1;
    check("ar_retires",   a_if.retire_count, 0);
    check("ar_cycles",    a_if.cycle_count, 0);
    check("ar_cpu_rst",   a_if.cpu_rst, 1);
    check("ar_b_retires", b_if.retire_count, 0);
    check("ar_b_cause",   b_if.cause, 0);
    rst = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Parametrised run controller for the pipelined CPU, instantiated beside the core in simulation and FPGA bring-up harnesses. Generates a programmable-length CPU reset pulse on request and counts cycles and retired instructions. Detects program completion when the end instruction address retires, and terminates runaway programs with a cycle limit and a no-retire watchdog. It replaces ad-hoc reset toggling and fixed-length runs with a single reusable, observable sequencer.

Parameters:
ADDR_W, 32, width of retire_pc and END_ADDR
END_ADDR, 32'ha0, instruction address whose retirement marks program completion
RST_CYCLES, 2, cycles cpu_rst is held high in RESET state (>=1)
MAX_CYCLES, 4096, RUN-cycle limit before timeout (>=2)
WDOG_CYCLES, 64, consecutive RUN cycles without retirement before timeout (>=2)
CNT_W, 32, width of cycle_count / retire_count

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset of this block
start  in  1  launch request; sampled in IDLE, DONE, TIMEOUT
abort  in  1  return to IDLE from any state
retire_valid  in  1  CPU retired one instruction this cycle
retire_pc  in  ADDR_W  address of the retired instruction
cpu_rst  out  1  active-high reset to the CPU
cpu_stall  out  1  freeze request to the CPU (DONE/TIMEOUT)
running  out  1  high in RUN
done  out  1  program completed
timeout  out  1  run terminated by limit or watchdog
cause  out  2  0 none, 1 end address, 2 cycle limit, 3 watchdog
cycle_count  out  CNT_W  RUN cycles elapsed
retire_count  out  CNT_W  instructions retired in RUN

Behaviour:
- One clock; reset is asynchronous and active-low (rst).
- All outputs registered or decoded from registered state; no input-to-output combinational path.
- rst low: state=IDLE, cpu_rst=1, cpu_stall=0, running=0, done=0, timeout=0, cause=0, counters=0, internal rst_cnt/wdog_cnt=0. Reset asserted mid-run behaves identically: the run is dropped.
- States: IDLE, RESET, RUN, DONE, TIMEOUT.
- IDLE: cpu_rst=1. start -> RESET; clears cycle_count, retire_count, cause, rst_cnt, wdog_cnt.
- RESET: cpu_rst=1 for exactly RST_CYCLES cycles. If start is sampled at edge N, cpu_rst falls and running rises after edge N+RST_CYCLES.
- RUN: cpu_rst=0, running=1.
  - cycle_count +1 each RUN cycle.
  - retire_count +1 on each retire_valid.
  - wdog_cnt clears on retire_valid and otherwise increments.
  - Both counters saturate at all-ones and never wrap.
- RUN exits, priority highest first:
  - retire_valid && retire_pc==END_ADDR -> DONE, cause=1. That retirement is counted.
  - cycle_count==MAX_CYCLES-1 -> TIMEOUT, cause=2.
  - wdog_cnt==WDOG_CYCLES-1 && !retire_valid -> TIMEOUT, cause=3.
  - Simultaneous conditions resolve by this priority.
- DONE: done=1, cpu_stall=1, cpu_rst=0. Counters and cause are frozen.
- TIMEOUT: timeout=1, cpu_stall=1, cpu_rst=0. Counters and cause are frozen.
- DONE/TIMEOUT persist until start (-> RESET, counters cleared) or abort (-> IDLE).
- abort in any state -> IDLE next edge. cause is cleared; counters hold their last values for inspection. abort wins over start on the same cycle.
- start in RESET or RUN is ignored.
- retire_valid outside RUN is ignored.
- done and timeout are never both 1. cause!=0 only in DONE/TIMEOUT.

Test Plan:
- Reset release, start pulse at edge 5, RST_CYCLES=2 -> cpu_rst high through edge 7, running=1 from edge 7, cycle_count=0 in first RUN cycle.
- Retire every cycle with pc 0x00,0x04..0xa0 -> DONE after the 0xa0 retirement, retire_count=41, cause=1, cpu_stall=1.
- No retire_valid after the first retirement, WDOG_CYCLES=64 -> TIMEOUT cause=3 exactly 64 cycles after the last retirement.
- MAX_CYCLES=16, retire every cycle, END_ADDR never reached -> TIMEOUT cause=2, cycle_count=15. Then start -> counters cleared, a new RESET pulse is issued.
- In the same cycle, retire END_ADDR at cycle_count==MAX_CYCLES-1 -> DONE with cause=1 (priority check).
- In mid-RUN, assert abort together with start -> IDLE, cpu_rst=1, cause=0. Then drop rst asynchronously between edges -> all outputs reach their reset values immediately.
